// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO: every one of the 2^ADDR_WIDTH entries is usable. Reads are either standard
// (registered) or first-word-fall-through. Also provides almost-full/empty thresholds and a synchronous flush.
module sync_fifo_ext #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  empty_int;
  logic                  wr_acc;
  logic                  rd_acc;

  // The count is a separate register, so pointer equality never has to tell full from empty.
  assign full   = (count_reg == DEPTH_C);
  assign wr_acc = wr_en && !full && !flush;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      overflow_reg  <= wr_en && full;
      underflow_reg <= rd_en && empty_int;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [ADDR_WIDTH:0] ram_count;
      logic                load;

      // count includes the head word already held in the output register.
      assign ram_count = count_reg - (ADDR_WIDTH+1)'(valid_reg);
      assign empty_int = !valid_reg;
      assign rd_acc    = rd_en && valid_reg && !flush;
      assign load      = (!valid_reg || rd_acc) && (ram_count != '0) && !flush;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr_reg   <= '0;
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else if (flush) begin
          rd_ptr_reg   <= '0;
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else if (load) begin
          data_out_reg <= mem[rd_ptr_reg];
          rd_ptr_reg   <= rd_ptr_reg + 1'b1;
          valid_reg    <= 1'b1;
        end else if (rd_acc) begin
          valid_reg <= 1'b0;
        end
      end
    end else begin : g_std
      assign empty_int = (count_reg == '0);
      assign rd_acc    = rd_en && !empty_int && !flush;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr_reg   <= '0;
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else if (flush) begin
          rd_ptr_reg   <= '0;
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else begin
          valid_reg <= rd_acc;
          if (rd_acc) begin
            data_out_reg <= mem[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign data_out     = data_out_reg;
  assign valid        = valid_reg;
  assign empty        = empty_int;
  assign count        = count_reg;
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard and an FWFT instance share one stimulus stream.
// Each instance is checked against its own queue-based reference model, and also against directed expectations.
module tb_sync_fifo_ext;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic [AW:0]   s_count, f_count;
  logic s_valid, s_empty, s_full, s_afull, s_aempty, s_ovf, s_unf;
  logic f_valid, f_empty, f_full, f_afull, f_aempty, f_ovf, f_unf;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(1)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(s_dout), .valid(s_valid), .empty(s_empty), .full(s_full),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // Reference models: the queue holds every stored word. For FWFT, m_f_vis says whether the head word is presented.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] m_s_dout, m_f_dout;
  logic m_s_valid, m_s_ovf, m_s_unf;
  logic m_f_vis, m_f_ovf, m_f_unf;

  typedef struct {
    logic          fl;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [AW:0]   cnt;
    logic          emp;
    logic          val;
    logic          ov;
    logic          un;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic fl, input logic wr, input logic rd, input logic [DW-1:0] din,
                              input logic [AW:0] cnt, input logic emp, input logic val, input logic ov,
                              input logic un, input logic [DW-1:0] dout);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.emp = emp; v.val = val; v.ov = ov; v.un = un; v.dout = dout;
    return v;
  endfunction

  function automatic logic [27:0] pack(input logic [DW-1:0] d, input logic [AW:0] c, input logic e,
                                       input logic fu, input logic af, input logic ae, input logic v,
                                       input logic o, input logic u);
    return {d, c, e, fu, af, ae, v, o, u};
  endfunction

  function automatic logic [27:0] exp_std();
    int n = sq.size();
    return pack(m_s_dout, (AW+1)'(n), n == 0, n == DEPTH, n >= 14, n <= 1, m_s_valid, m_s_ovf, m_s_unf);
  endfunction

  function automatic logic [27:0] exp_fwft();
    int n = fq.size();
    return pack(m_f_dout, (AW+1)'(n), !m_f_vis, n == DEPTH, n >= 14, n <= 1, m_f_vis, m_f_ovf, m_f_unf);
  endfunction

  task automatic model_clear();
    sq.delete();
    fq.delete();
    m_s_dout = '0; m_s_valid = 1'b0; m_s_ovf = 1'b0; m_s_unf = 1'b0;
    m_f_dout = '0; m_f_vis = 1'b0; m_f_ovf = 1'b0; m_f_unf = 1'b0;
  endtask

  task automatic model_edge();
    int  sn, fn, ram_before;
    logic wa, ra, vis_next;
    if (flush) begin
      model_clear();
      return;
    end
    sn = sq.size();
    m_s_ovf = wr_en && (sn == DEPTH);
    m_s_unf = rd_en && (sn == 0);
    ra = rd_en && (sn != 0);
    wa = wr_en && (sn != DEPTH);
    m_s_valid = ra;
    if (ra) m_s_dout = sq.pop_front();
    if (wa) sq.push_back(data_in);

    fn = fq.size();
    m_f_ovf = wr_en && (fn == DEPTH);
    m_f_unf = rd_en && !m_f_vis;
    ra = rd_en && m_f_vis;
    wa = wr_en && (fn != DEPTH);
    ram_before = fn - (m_f_vis ? 1 : 0);
    if (ra) void'(fq.pop_front());
    // A word that was already in storage becomes the presented head; a word written at this edge does not.
    vis_next = (ram_before > 0) || (m_f_vis && !ra);
    if (vis_next) m_f_dout = fq[0];
    m_f_vis = vis_next;
    if (wa) fq.push_back(data_in);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("std_model", 64'(pack(s_dout, s_count, s_empty, s_full, s_afull, s_aempty, s_valid, s_ovf, s_unf)),
        64'(exp_std()));
    chk("fwft_model", 64'(pack(f_dout, f_count, f_empty, f_full, f_afull, f_aempty, f_valid, f_ovf, f_unf)),
        64'(exp_fwft()));
  endtask

  task automatic drive(input logic fl, input logic wr, input logic rd, input logic [DW-1:0] din);
    flush = fl; wr_en = wr; rd_en = rd; data_in = din;
    cycle();
    $display("t=%0t fl=%0b wr=%0b rd=%0b din=%h | std cnt=%0d dout=%h v=%0b | fwft cnt=%0d dout=%h e=%0b",
             $time, fl, wr, rd, din, s_count, s_dout, s_valid, f_count, f_dout, f_empty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 16'h00AA, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 16'h00BB, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 16'h0000, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00BB);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00BB);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 16'h00CC, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00BB);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 16'h0011, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00BB);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 16'h0022, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00BB);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 16'h0033, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 16'h00AA, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA);

    model_clear();
    #2 rst = 1'b1;
    #11;
    chk("reset_std", 64'(pack(s_dout, s_count, s_empty, s_full, s_afull, s_aempty, s_valid, s_ovf, s_unf)),
        64'(pack(16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
    chk("reset_fwft", 64'(pack(f_dout, f_count, f_empty, f_full, f_afull, f_aempty, f_valid, f_ovf, f_unf)),
        64'(pack(16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors against the standard-mode instance
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d", i), 64'({s_dout, s_count, s_empty, s_valid, s_ovf, s_unf}),
          64'({vecs[i].dout, vecs[i].cnt, vecs[i].emp, vecs[i].val, vecs[i].ov, vecs[i].un}));
    end

    // Fill to full, overflow, simultaneous request at full, then drain
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'(i));
      chk("fill_count", 64'(s_count), 64'(i + 1));
      chk("fill_full", 64'(s_full), 64'(i == DEPTH - 1));
      chk("fill_afull", 64'(s_afull), 64'((i + 1) >= 14));
      chk("fill_aempty", 64'(s_aempty), 64'((i + 1) <= 1));
    end
    drive(1'b0, 1'b1, 1'b0, 16'h00EE);
    chk("ovf_std", 64'({s_ovf, s_count}), 64'({1'b1, 5'd16}));
    chk("ovf_fwft", 64'({f_ovf, f_count}), 64'({1'b1, 5'd16}));
    drive(1'b0, 1'b1, 1'b1, 16'h0077);
    chk("full_wr_rd_std", 64'({s_ovf, s_valid, s_count, s_dout}), 64'({1'b1, 1'b1, 5'd15, 16'h0000}));
    chk("full_wr_rd_fwft", 64'({f_ovf, f_count}), 64'({1'b1, 5'd15}));
    drive(1'b0, 1'b1, 1'b0, 16'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fwft_head", 64'({f_empty, f_dout}), 64'({1'b0, 16'(i + 1)}));
      drive(1'b0, 1'b0, 1'b1, 16'h0);
      chk("drain_data", 64'({s_valid, s_dout}), 64'({1'b1, 16'(i + 1)}));
      chk("drain_afull", 64'(s_afull), 64'((15 - i) >= 14));
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0);
    chk("unf_std", 64'({s_unf, s_count}), 64'({1'b1, 5'd0}));
    chk("unf_fwft", 64'({f_unf, f_count}), 64'({1'b1, 5'd0}));

    // Accepted read and write together at count 7
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, 16'(100 + i));
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 16'd200);
    chk("mid_wr_rd_std", 64'({s_count, s_dout}), 64'({5'd7, 16'd100}));
    chk("mid_wr_rd_fwft", 64'({f_count, f_dout}), 64'({5'd7, 16'd101}));

    // FWFT write-to-empty latency
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h1234);
    chk("fwft_lat1", 64'({f_empty, f_count, s_empty}), 64'({1'b1, 5'd1, 1'b0}));
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("fwft_lat2", 64'({f_empty, f_valid, f_dout}), 64'({1'b0, 1'b1, 16'h1234}));

    // Asynchronous reset with 5 words held
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 16'(50 + i));
    drive(1'b0, 1'b0, 1'b1, 16'h0);
    chk("pre_rst", 64'({s_count, s_dout, f_count}), 64'({5'd5, 16'd50, 5'd5}));
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_std", 64'({s_count, s_empty, s_dout}), 64'({5'd0, 1'b1, 16'h0}));
    chk("async_rst_fwft", 64'({f_count, f_empty, f_dout}), 64'({5'd0, 1'b1, 16'h0}));
    @(negedge clk);
    rst = 1'b0;

    // Random interleaving with occupancy held in 10..16 to exercise pointer wrap
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 200; i++) begin
      int  n;
      logic w, r;
      n = sq.size();
      w = (n <= 10) ? 1'b1 : ((n >= DEPTH) ? 1'b0 : 1'($urandom_range(0, 1)));
      r = (n >= DEPTH) ? 1'b1 : ((n <= 10) ? 1'b0 : 1'($urandom_range(0, 1)));
      drive(1'b0, w, r, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
